// File: rtl/ltssm_pkg.sv
// rtl/ltssm_pkg.sv - shared LTSSM state codes, ordered-set types and match thresholds
package ltssm_pkg;

  typedef enum logic [3:0] {
    DetectQuiet                 = 4'b0000,
    DetectActive                = 4'b0001,
    PollingActive               = 4'b0010,
    PollingConfigration         = 4'b0011,
    ConfigrationLinkWidthStart  = 4'b0100,
    ConfigrationLinkWidthAccept = 4'b0101,
    ConfigrationLaneNumWait     = 4'b0110,
    ConfigrationLaneNumActive   = 4'b0111,
    ConfigrationComplete        = 4'b1000,
    ConfigrationIdle            = 4'b1001,
    L0                          = 4'b1010,
    Idle                        = 4'b1111
  } ltssmState_e;

  typedef enum logic [2:0] {
    OsTs1  = 3'b000,
    OsTs2  = 3'b001,
    OsIdle = 3'b100
  } osType_e;

  localparam logic [7:0] PadSymbol   = 8'hF7;
  localparam logic [3:0] ThreshLong  = 4'd8;
  localparam logic [3:0] ThreshShort = 4'd2;

endpackage

// File: rtl/os_match_counter.sv
// rtl/os_match_counter.sv - saturating consecutive ordered-set match counter
module os_match_counter (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       Match,
  input  logic       Mismatch,
  input  logic [3:0] Threshold,
  output logic [3:0] Count,
  output logic       Hit
);

  logic [3:0] nextCount;

  // Match together with Mismatch restarts the run with the current OS as its first member.
  always_comb begin
    nextCount = Count;
    if (Clear) begin
      nextCount = 4'd0;
    end else if (Match && Mismatch) begin
      nextCount = 4'd1;
    end else if (Mismatch) begin
      nextCount = 4'd0;
    end else if (Match && (Count != 4'd15)) begin
      nextCount = Count + 4'd1;
    end
  end

  assign Hit = Match && !Clear && (nextCount >= Threshold);

  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      Count <= 4'd0;
    end else begin
      Count <= nextCount;
    end
  end

endmodule

// File: rtl/rx_ltssm.sv
// rtl/rx_ltssm.sv - receive-side LTSSM: ordered-set qualification, match counting, timeout exits
module rx_ltssm
  import ltssm_pkg::*;
#(
  parameter int          LANESNUMBER    = 16,
  parameter int          DEVICETYPE     = 0,
  parameter logic [7:0]  PAD            = PadSymbol,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000
) (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic [3:0] SetRXState,
  input  logic       OSValid,
  input  logic [2:0] OSType,
  input  logic [7:0] RxLinkNumber,
  input  logic [7:0] RxLaneNumber,
  input  logic [7:0] ReadLinkNum,
  output logic       RXFinishFlag,
  output logic [3:0] RXExitTo,
  output logic [7:0] WriteLinkNum,
  output logic       WriteLinkNumFlag
);

  localparam bit IsUpstream = (DEVICETYPE == 1);

  ltssmState_e State;
  ltssmState_e target;
  logic [31:0] timer;
  logic        done;
  logic [7:0]  seedLink;
  logic [3:0]  threshold;
  logic [3:0]  matchCount;
  logic        stateChange, timed, osMatch, osEvent;
  logic        isTs1, isTs2, isIdle, linkOk, laneOk;
  logic        upstreamLws, linkRestart;
  logic        cntMatch, cntMismatch, cntHit;
  logic        fireThresh, fireTimeout;
  logic        unusedLanes;

  assign unusedLanes = (LANESNUMBER > 0);

  assign stateChange = (SetRXState != State);
  assign isTs1       = (OSType == OsTs1);
  assign isTs2       = (OSType == OsTs2);
  assign isIdle      = (OSType == OsIdle);
  assign linkOk      = (RxLinkNumber == ReadLinkNum);
  assign laneOk      = (RxLaneNumber != PAD);

  always_comb begin
    timed     = 1'b1;
    osMatch   = 1'b0;
    threshold = ThreshLong;
    target    = DetectQuiet;
    case (State)
      PollingActive: begin
        osMatch = isTs1 || isTs2;
        target  = PollingConfigration;
      end
      PollingConfigration: begin
        osMatch = isTs2;
        target  = ConfigrationLinkWidthStart;
      end
      ConfigrationLinkWidthStart: begin
        // Upstream has no stored link yet, so it only needs a stable non-PAD proposal.
        osMatch   = isTs1 && (RxLinkNumber != PAD) && (IsUpstream || linkOk);
        threshold = ThreshShort;
        target    = ConfigrationLinkWidthAccept;
      end
      ConfigrationLaneNumWait: begin
        osMatch   = isTs1 && linkOk && laneOk;
        threshold = ThreshShort;
        target    = ConfigrationLaneNumActive;
      end
      ConfigrationLaneNumActive: begin
        osMatch   = isTs2 && linkOk && laneOk;
        threshold = ThreshShort;
        target    = ConfigrationComplete;
      end
      ConfigrationComplete: begin
        osMatch = isTs2 && linkOk;
        target  = ConfigrationIdle;
      end
      ConfigrationIdle: begin
        osMatch = isIdle;
        target  = L0;
      end
      default: timed = 1'b0;
    endcase
  end

  // A changed upstream link proposal starts a new run seeded by that link.
  assign upstreamLws = IsUpstream && (State == ConfigrationLinkWidthStart);
  assign linkRestart = upstreamLws && osMatch && (matchCount != 4'd0) && (RxLinkNumber != seedLink);

  assign osEvent     = OSValid && timed && !stateChange;
  assign cntMatch    = osEvent && osMatch;
  assign cntMismatch = osEvent && (!osMatch || linkRestart);

  os_match_counter uMatchCounter (
    .Pclk      (Pclk),
    .Reset     (Reset),
    .Clear     (stateChange),
    .Match     (cntMatch),
    .Mismatch  (cntMismatch),
    .Threshold (threshold),
    .Count     (matchCount),
    .Hit       (cntHit)
  );

  assign fireThresh  = cntHit && !done;
  assign fireTimeout = timed && !stateChange && !done && (timer == TIMEOUT_CYCLES);

  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      State            <= Idle;
      timer            <= 32'd0;
      done             <= 1'b0;
      seedLink         <= 8'h00;
      RXFinishFlag     <= 1'b0;
      RXExitTo         <= 4'b0000;
      WriteLinkNum     <= 8'h00;
      WriteLinkNumFlag <= 1'b0;
    end else begin
      State            <= ltssmState_e'(SetRXState);
      RXFinishFlag     <= fireThresh || fireTimeout;
      WriteLinkNumFlag <= 1'b0;
      if (stateChange) begin
        timer <= 32'd0;
        done  <= 1'b0;
      end else begin
        if (timed && (timer < TIMEOUT_CYCLES)) begin
          timer <= timer + 32'd1;
        end
        if (fireThresh || fireTimeout) begin
          done <= 1'b1;
        end
        // Threshold has priority over a timeout landing on the same edge.
        if (fireThresh) begin
          RXExitTo <= target;
          if (upstreamLws) begin
            WriteLinkNum     <= RxLinkNumber;
            WriteLinkNumFlag <= 1'b1;
          end
        end else if (fireTimeout) begin
          RXExitTo <= DetectQuiet;
        end
      end
      if (upstreamLws && cntMatch) begin
        seedLink <= RxLinkNumber;
      end
    end
  end

endmodule

// File: tb/tb_rx_ltssm.sv
// tb/tb_rx_ltssm.sv - self-checking bench for rx_ltssm, downstream and upstream instances side by side
module tb_rx_ltssm;

  localparam int TOUT = 100;

  logic       Pclk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] SetRXState = 4'hF;
  logic       OSValid = 1'b0;
  logic [2:0] OSType = 3'b000;
  logic [7:0] RxLinkNumber = 8'h00;
  logic [7:0] RxLaneNumber = 8'h00;
  logic [7:0] ReadLinkNum = 8'h00;

  logic       finDn, finUp, wfDn, wfUp;
  logic [3:0] exDn, exUp;
  logic [7:0] wlDn, wlUp;

  always #5 Pclk = ~Pclk;

  rx_ltssm #(.LANESNUMBER(16), .DEVICETYPE(0), .PAD(8'hF7), .TIMEOUT_CYCLES(32'd100)) dutDn (
    .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState), .OSValid(OSValid), .OSType(OSType),
    .RxLinkNumber(RxLinkNumber), .RxLaneNumber(RxLaneNumber), .ReadLinkNum(ReadLinkNum),
    .RXFinishFlag(finDn), .RXExitTo(exDn), .WriteLinkNum(wlDn), .WriteLinkNumFlag(wfDn)
  );

  rx_ltssm #(.LANESNUMBER(16), .DEVICETYPE(1), .PAD(8'hF7), .TIMEOUT_CYCLES(32'd100)) dutUp (
    .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState), .OSValid(OSValid), .OSType(OSType),
    .RxLinkNumber(RxLinkNumber), .RxLaneNumber(RxLaneNumber), .ReadLinkNum(ReadLinkNum),
    .RXFinishFlag(finUp), .RXExitTo(exUp), .WriteLinkNum(wlUp), .WriteLinkNumFlag(wfUp)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulsesDn = 0;
  int pulsesUp = 0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the ordered sets seen in the current state visit and derives exits from them.
  typedef struct packed {
    logic [2:0] t;
    logic [7:0] link;
    logic [7:0] lane;
    logic [7:0] read;
  } osRec_t;

  osRec_t     hist[$];
  int         thr[16];
  logic [3:0] tgt[16];
  logic [2:0] pref[16];
  logic [3:0] mState = 4'hF;
  int         edges = 0;
  bit         exited[2];
  logic       expFin[2];
  logic       expWf[2];
  logic [3:0] expExit[2];
  logic [7:0] expWl[2];

  function automatic bit ruleOk(input logic [3:0] s, input osRec_t o);
    case (s)
      4'd2: return (o.t == 3'b000) || (o.t == 3'b001);
      4'd3: return o.t == 3'b001;
      4'd4: return (o.t == 3'b000) && (o.link != 8'hF7) && (o.link == o.read);
      4'd6: return (o.t == 3'b000) && (o.link == o.read) && (o.lane != 8'hF7);
      4'd7: return (o.t == 3'b001) && (o.link == o.read) && (o.lane != 8'hF7);
      4'd8: return (o.t == 3'b001) && (o.link == o.read);
      4'd9: return o.t == 3'b100;
      default: return 1'b0;
    endcase
  endfunction

  // Length of the trailing run of qualifying OSs; upstream link-width counts identical proposed links.
  function automatic int runLen(input int d);
    int n;
    osRec_t last;
    n = 0;
    last = hist[hist.size() - 1];
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (d == 1 && mState == 4'd4) begin
        if (!((hist[i].t == 3'b000) && (hist[i].link != 8'hF7) && (hist[i].link == last.link))) break;
      end else if (!ruleOk(mState, hist[i])) begin
        break;
      end
      n++;
    end
    return n;
  endfunction

  task automatic modelReset();
    mState = 4'hF;
    hist.delete();
    edges = 0;
    for (int d = 0; d < 2; d++) begin
      exited[d] = 1'b0; expFin[d] = 1'b0; expWf[d] = 1'b0; expExit[d] = 4'h0; expWl[d] = 8'h00;
    end
  endtask

  task automatic modelStep();
    osRec_t rec;
    for (int d = 0; d < 2; d++) begin
      expFin[d] = 1'b0;
      expWf[d] = 1'b0;
    end
    if (SetRXState != mState) begin
      mState = SetRXState;
      hist.delete();
      edges = 0;
      for (int d = 0; d < 2; d++) exited[d] = 1'b0;
    end else if (thr[mState] != 0) begin
      edges++;
      if (OSValid) begin
        rec = '{OSType, RxLinkNumber, RxLaneNumber, ReadLinkNum};
        hist.push_back(rec);
      end
      for (int d = 0; d < 2; d++) begin
        if (!exited[d]) begin
          if (OSValid && runLen(d) >= thr[mState]) begin
            expFin[d] = 1'b1; expExit[d] = tgt[mState]; exited[d] = 1'b1;
            if (d == 1 && mState == 4'd4) begin
              expWl[d] = RxLinkNumber; expWf[d] = 1'b1;
            end
          end else if (edges == TOUT + 1) begin
            expFin[d] = 1'b1; expExit[d] = 4'h0; exited[d] = 1'b1;
          end
        end
      end
    end
  endtask

  // Compare process: outputs of the previous edge, then advance the model with the inputs for the next edge.
  initial begin
    modelReset();
    forever begin
      @(negedge Pclk);
      if (!Reset) modelReset();
      cmp("fin_dn", {7'b0, finDn}, {7'b0, expFin[0]});
      cmp("fin_up", {7'b0, finUp}, {7'b0, expFin[1]});
      cmp("exit_dn", {4'b0, exDn}, {4'b0, expExit[0]});
      cmp("exit_up", {4'b0, exUp}, {4'b0, expExit[1]});
      cmp("wlnum_dn", wlDn, expWl[0]);
      cmp("wlnum_up", wlUp, expWl[1]);
      cmp("wlflag_dn", {7'b0, wfDn}, {7'b0, expWf[0]});
      cmp("wlflag_up", {7'b0, wfUp}, {7'b0, expWf[1]});
      pulsesDn += int'(finDn);
      pulsesUp += int'(finUp);
      if (Reset) modelStep();
    end
  end

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic idle(input int n);
    OSValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic sendOs(input logic [2:0] t, input logic [7:0] link, input logic [7:0] lane);
    OSValid = 1'b1; OSType = t; RxLinkNumber = link; RxLaneNumber = lane;
    tick();
    OSValid = 1'b0;
  endtask

  task automatic setState(input logic [3:0] s);
    SetRXState = s;
    OSValid = 1'b0;
    tick();
  endtask

  int stList[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15};
  int p0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      thr[i] = 0; tgt[i] = 4'h0; pref[i] = 3'b000;
    end
    thr[2] = 8; tgt[2] = 4'd3;
    thr[3] = 8; tgt[3] = 4'd4;  pref[3] = 3'b001;
    thr[4] = 2; tgt[4] = 4'd5;
    thr[6] = 2; tgt[6] = 4'd7;
    thr[7] = 2; tgt[7] = 4'd8;  pref[7] = 3'b001;
    thr[8] = 8; tgt[8] = 4'd9;  pref[8] = 3'b001;
    thr[9] = 8; tgt[9] = 4'd10; pref[9] = 3'b100;

    repeat (2) tick();
    cmp("rst_fin", {7'b0, finDn}, 8'h00);
    cmp("rst_exit", {4'b0, exUp}, 8'h00);
    cmp("rst_wlnum", wlUp, 8'h00);
    Reset = 1'b1;
    idle(2);

    // PollingActive: 8 TS1, one every 4 cycles
    setState(4'd2);
    p0 = pulsesDn;
    for (int i = 0; i < 8; i++) begin
      idle(3);
      sendOs(3'b000, 8'h05, 8'h00);
    end
    cmp("pa_fin", {7'b0, finDn}, 8'h01);
    cmp("pa_exit", {4'b0, exDn}, 8'h03);
    idle(1);
    cmp("pa_one_wide", {7'b0, finDn}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      idle(3);
      sendOs(3'b000, 8'h05, 8'h00);
    end
    idle(1);
    cmp("pa_pulses", 8'(pulsesDn - p0), 8'd1);

    // PollingConfigration: 5 TS2, 1 TS1, 8 TS2
    setState(4'd3);
    p0 = pulsesDn;
    for (int i = 0; i < 14; i++) begin
      sendOs((i == 5) ? 3'b000 : 3'b001, 8'h05, 8'h00);
      if (i == 12) cmp("pc_no_early", {7'b0, finDn}, 8'h00);
    end
    cmp("pc_fin", {7'b0, finDn}, 8'h01);
    cmp("pc_exit", {4'b0, exDn}, 8'h04);
    idle(2);
    cmp("pc_pulses", 8'(pulsesDn - p0), 8'd1);

    // LinkWidthStart: links 05, 07, 07 against stored link 07
    ReadLinkNum = 8'h07;
    setState(4'd4);
    sendOs(3'b000, 8'h05, 8'h00);
    sendOs(3'b000, 8'h07, 8'h00);
    cmp("lws_no_early", {7'b0, finUp}, 8'h00);
    sendOs(3'b000, 8'h07, 8'h00);
    cmp("lws_fin_up", {7'b0, finUp}, 8'h01);
    cmp("lws_wlflag_up", {7'b0, wfUp}, 8'h01);
    cmp("lws_wlnum_up", wlUp, 8'h07);
    cmp("lws_exit_up", {4'b0, exUp}, 8'h05);
    cmp("lws_fin_dn", {7'b0, finDn}, 8'h01);
    cmp("lws_wlflag_dn", {7'b0, wfDn}, 8'h00);
    idle(2);

    // ConfigrationComplete timeout with no ordered sets
    setState(4'd8);
    idle(100);
    cmp("to_not_yet", {7'b0, finDn}, 8'h00);
    idle(1);
    cmp("to_fin", {7'b0, finDn}, 8'h01);
    cmp("to_exit", {4'b0, exDn}, 8'h00);
    idle(2);

    // 8th TS2 lands on the timeout edge: threshold wins
    setState(4'hF);
    setState(4'd8);
    for (int k = 1; k <= 101; k++) begin
      OSValid = ((k % 10 == 0) && (k <= 70)) || (k == 101);
      OSType = 3'b001; RxLinkNumber = 8'h07; RxLaneNumber = 8'h00;
      tick();
      if (k == 100) cmp("col_not_yet", {7'b0, finDn}, 8'h00);
    end
    OSValid = 1'b0;
    cmp("col_fin", {7'b0, finDn}, 8'h01);
    cmp("col_exit", {4'b0, exDn}, 8'h09);
    idle(2);

    // ConfigrationIdle interrupted by a state change, then a full run
    setState(4'd9);
    p0 = pulsesDn;
    for (int i = 0; i < 4; i++) sendOs(3'b100, 8'h00, 8'h00);
    setState(4'd2);
    idle(2);
    setState(4'd9);
    for (int i = 0; i < 8; i++) sendOs(3'b100, 8'h00, 8'h00);
    cmp("ci_fin", {7'b0, finDn}, 8'h01);
    cmp("ci_exit", {4'b0, exDn}, 8'h0A);
    idle(2);
    cmp("ci_pulses", 8'(pulsesDn - p0), 8'd1);

    // Reset mid-count clears outputs at once
    setState(4'd2);
    for (int i = 0; i < 5; i++) sendOs(3'b000, 8'h00, 8'h00);
    @(posedge Pclk);
    #2 Reset = 1'b0;
    #1;
    cmp("mid_rst_exit", {4'b0, exDn}, 8'h00);
    cmp("mid_rst_wlnum", wlUp, 8'h00);
    cmp("mid_rst_fin", {7'b0, finUp}, 8'h00);
    tick();
    Reset = 1'b1;
    idle(3);

    // Randomized traffic checked against the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) SetRXState = 4'(stList[$urandom_range(11)]);
      if ($urandom_range(99) == 0) ReadLinkNum = ($urandom_range(1) == 1) ? 8'h05 : 8'h07;
      OSValid = ($urandom_range(1) == 1);
      OSType = ($urandom_range(9) < 7) ? pref[SetRXState] : 3'($urandom_range(7));
      RxLinkNumber = ($urandom_range(9) < 8) ? ReadLinkNum : (($urandom_range(1) == 1) ? 8'hF7 : 8'h05);
      RxLaneNumber = ($urandom_range(9) < 8) ? 8'h00 : 8'hF7;
      if (c == 1500) Reset = 1'b0;
      if (c == 1502) Reset = 1'b1;
      tick();
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_ltssm.md
# rx_ltssm

Receive-side LTSSM sub-block, paired with the transmit-side LTSSM under the main LTSSM controller. Qualifies ordered sets delivered by the OS decoder (TS1, TS2, IDLE) against per-state match rules. Counts consecutive matches and enforces a per-state timeout. Reports each exit condition to the main LTSSM as a one-cycle finish pulse plus a target state. Upstream devices also capture the link number proposed by the downstream port.

## Interface
Parameters:
- LANESNUMBER, 16, lane count (informational; per-lane gating is done by the decoder)
- DEVICETYPE, 0, 0 = downstream, 1 = upstream
- PAD, 8'hF7, PAD symbol value for the link/lane fields
- TIMEOUT_CYCLES, 32'd3000000, Pclk cycles spent in a timed state before the timeout exit

Ports:
- Pclk  in  1  clock
- Reset  in  1  reset; asynchronous, active-low
- SetRXState  in  4  current state commanded by the main LTSSM (shared state codes)
- OSValid  in  1  one-cycle strobe, one per decoded ordered set
- OSType  in  3  3'b000 TS1, 3'b001 TS2, 3'b100 IDLE, other = ignored non-match
- RxLinkNumber  in  8  link field of the decoded TS
- RxLaneNumber  in  8  lane field of the decoded TS
- ReadLinkNum  in  8  link number currently stored by the main LTSSM
- RXFinishFlag  out  1  one-cycle exit pulse
- RXExitTo  out  4  exit target; valid while RXFinishFlag = 1, held afterwards
- WriteLinkNum  out  8  captured link number (upstream only)
- WriteLinkNumFlag  out  1  one-cycle write strobe for WriteLinkNum

## Operation
- State: registered copy of SetRXState. A state change is a cycle where SetRXState != State. On a state change:
  - match counter is cleared to 0
  - timer is cleared to 0
  - done latch is cleared
  - OSValid in that same cycle is ignored
- Match counter: 4 bits, saturates at 15.
  - OSValid with a matching OS: increment.
  - OSValid with a non-matching OS: reset to 0. Consecutive semantics apply; a reset does not carry over the current OS.
  - Cycles without OSValid leave the count unchanged.
- Match rules and thresholds (threshold reached → exit to target):
  - PollingActive (0010): TS1 or TS2, any fields; threshold 8 → PollingConfigration.
  - PollingConfigration (0011): TS2; threshold 8 → ConfigrationLinkWidthStart.
  - ConfigrationLinkWidthStart (0100): TS1 with link != PAD.
    - Downstream: link must also equal ReadLinkNum.
    - Upstream: link must equal the link of the previous matching TS1; the first one seeds the comparison.
    - Threshold 2 → ConfigrationLinkWidthAccept.
    - Upstream only: on the exit, WriteLinkNum = that link and WriteLinkNumFlag pulses together with RXFinishFlag.
  - ConfigrationLaneNumWait (0110): TS1, link == ReadLinkNum, lane != PAD; threshold 2 → ConfigrationLaneNumActive.
  - ConfigrationLaneNumActive (0111): TS2, link == ReadLinkNum, lane != PAD; threshold 2 → ConfigrationComplete.
  - ConfigrationComplete (1000): TS2, link == ReadLinkNum; threshold 8 → ConfigrationIdle.
  - ConfigrationIdle (1001): IDLE; threshold 8 → L0.
  - DetectQuiet, DetectActive, ConfigrationLinkWidthAccept, L0, Idle: no matching, no timer, no exits.
- Timeout:
  - Timed states: all states that have a match rule.
  - The timer counts every cycle in a timed state.
  - When the timer reaches TIMEOUT_CYCLES with no exit fired, exit to DetectQuiet (0000).
- Done latch: set on any exit. While set, no further exits fire in that state (one pulse per state visit).
- Simultaneous threshold and timeout in the same cycle: the threshold exit wins.

## Timing
- Reset values:
  - RXFinishFlag 0, RXExitTo 4'b0000, WriteLinkNum 8'h00, WriteLinkNumFlag 0
  - State 4'b1111 (Idle), counter 0, timer 0, done 0
- Reset asserted mid-operation: all of the above are forced immediately (asynchronous). No pulse is emitted on reset release.
- Latency:
  - The OSValid that completes a threshold at edge N produces RXFinishFlag = 1 in cycle N+1, with RXExitTo valid in the same cycle.
  - Timeout: RXFinishFlag asserts in the cycle after the timer equals TIMEOUT_CYCLES.
- RXFinishFlag and WriteLinkNumFlag are exactly one cycle wide.
- RXExitTo holds its last value until the next exit.
- The main LTSSM may leave the state at any time. Counting in the new state starts from the first OSValid after the change cycle.

## Structure
- Shared package ltssm_pkg holds:
  - 4-bit state codes (shared with the TX LTSSM)
  - OS type codes
  - PAD
  - thresholds: 8 (POLL/COMPLETE/IDLE) and 2 (LINK/LANE)
- One sub-module, os_match_counter: saturating consecutive counter with match/mismatch/clear inputs and a threshold compare output.
- Top level holds the match decode, the timer, the done latch and the output registers.

## Test plan
- PollingActive, 8 TS1 strobes one every 4 cycles → single RXFinishFlag pulse one cycle after the 8th strobe, RXExitTo = 0011; further TS1 strobes produce no pulse.
- PollingConfigration, 5 TS2, 1 TS1, 8 TS2 → pulse only after the 14th OS, RXExitTo = 0100.
- Upstream, LinkWidthStart, TS1 links 8'h05, 8'h07, 8'h07 → pulse after the 3rd OS, WriteLinkNum = 8'h07, WriteLinkNumFlag coincident; the same stimulus with DEVICETYPE = 0 and ReadLinkNum = 8'h07 also exits, with no write strobe.
- TIMEOUT_CYCLES = 100, ConfigrationComplete with no OSValid → pulse in cycle 101, RXExitTo = 0000; 8th TS2 landing on the timeout cycle → RXExitTo = 1001.
- ConfigrationIdle, 4 IDLE, then SetRXState changes to PollingActive and back, then 8 IDLE → exactly one pulse, RXExitTo = 1010, after the last 8; Reset pulsed mid-count clears all outputs immediately.
